// File: rtl/e_mdu.sv
// Multiply/divide unit with architectural HI/LO; mult/div results commit after a fixed busy window.
// Latency MULT_CYCLES / DIV_CYCLES; starts while busy are dropped, so external hazard logic stalls on MDUStart|Busy.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic        MDUStart,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] MDUOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1) + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   stg_hi, stg_lo;
  logic          stg_wr;

  logic          is_mul, is_div, is_signed, launch, done;
  logic [63:0]   mul_a, mul_b, product;
  logic          a_neg, b_neg, div_zero;
  logic [31:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
  logic [31:0]   res_hi, res_lo;

  assign is_mul    = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
  assign is_div    = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
  assign is_signed = (MDUOp == OP_MULT) || (MDUOp == OP_DIV);
  assign launch    = (state == IDLE) && MDUStart && (is_mul || is_div);
  assign done      = (state == BUSY) && (cnt <= CW'(1));

  // Sign-extending to 64 bits makes the low 64 bits of an unsigned product the signed result.
  assign mul_a   = {{32{is_signed & A[31]}}, A};
  assign mul_b   = {{32{is_signed & B[31]}}, B};
  assign product = mul_a * mul_b;

  // Divide magnitudes then restore signs; covers 0x80000000 / -1 without overflow special-casing.
  assign a_neg    = is_signed & A[31];
  assign b_neg    = is_signed & B[31];
  assign a_mag    = a_neg ? (~A + 32'd1) : A;
  assign b_mag    = b_neg ? (~B + 32'd1) : B;
  assign div_zero = (B == 32'd0);
  assign b_safe   = div_zero ? 32'd1 : b_mag;
  assign q_mag    = a_mag / b_safe;
  assign r_mag    = a_mag % b_safe;
  assign quot     = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem      = a_neg ? (~r_mag + 32'd1) : r_mag;

  assign res_hi = is_mul ? product[63:32] : rem;
  assign res_lo = is_mul ? product[31:0]  : quot;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = BUSY;
      BUSY:    if (done)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      stg_hi <= '0;
      stg_lo <= '0;
      stg_wr <= 1'b0;
      HI     <= '0;
      LO     <= '0;
    end else if (state == IDLE) begin
      if (launch) begin
        stg_hi <= res_hi;
        stg_lo <= res_lo;
        stg_wr <= !(is_div && div_zero);
        cnt    <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      end
      if (MDUOp == OP_MTHI) HI <= A;
      if (MDUOp == OP_MTLO) LO <= A;
    end else begin
      cnt <= cnt - CW'(1);
      if (done && stg_wr) begin
        HI <= stg_hi;
        LO <= stg_lo;
      end
    end
  end

  assign Busy = (state == BUSY);

  always_comb begin
    MDUOut = 32'd0;
    case (MDUOp)
      OP_MFHI: MDUOut = HI;
      OP_MFLO: MDUOut = LO;
      default: MDUOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed-vector bench for e_mdu: timing of Busy, HI/LO results, corner cases and mid-operation reset.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDUOp;
  logic        MDUStart;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] MDUOut, HI, LO;

  int vectors = 0;
  int miscompares = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MDUOp(MDUOp), .MDUStart(MDUStart),
    .A(A), .B(B), .Busy(Busy), .MDUOut(MDUOut), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a start for one edge (edge T), return 1ns after it with the request removed.
  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    MDUOp = op; A = a; B = b; MDUStart = 1'b1;
    step();
    MDUStart = 1'b0; MDUOp = 4'd0;
  endtask

  // Busy must be high after edges T..T+n-1 and low after edge T+n; HI/LO held until then.
  task automatic wait_busy(input int n, input string tag, input logic [31:0] hi_old, input logic [31:0] lo_old);
    for (int k = 0; k < n; k++) begin
      check({tag, " busy"}, {31'd0, Busy}, 32'd1);
      if (k == n - 1) begin
        check({tag, " hi held"}, HI, hi_old);
        check({tag, " lo held"}, LO, lo_old);
      end
      step();
    end
    check({tag, " busy low"}, {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; MDUOp = 4'd0; MDUStart = 1'b0; A = '0; B = '0;
    #3;
    check("rst busy", {31'd0, Busy}, 32'd0);
    check("rst hi", HI, 32'd0);
    check("rst lo", LO, 32'd0);
    step();
    reset = 1'b0;

    // signed multiply -2 * 3
    launch(4'd1, 32'hFFFFFFFE, 32'd3);
    wait_busy(5, "mult", 32'd0, 32'd0);
    check("mult hi", HI, 32'hFFFFFFFF);
    check("mult lo", LO, 32'hFFFFFFFA);
    MDUOp = 4'd5; #1;
    check("mfhi", MDUOut, 32'hFFFFFFFF);
    MDUOp = 4'd6; #1;
    check("mflo", MDUOut, 32'hFFFFFFFA);
    MDUOp = 4'd9; #1;
    check("mdu out other", MDUOut, 32'd0);
    MDUOp = 4'd0;

    launch(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_busy(5, "multu", 32'hFFFFFFFF, 32'hFFFFFFFA);
    check("multu hi", HI, 32'hFFFFFFFE);
    check("multu lo", LO, 32'h00000001);

    launch(4'd3, 32'hFFFFFFF9, 32'd2);
    wait_busy(10, "div", 32'hFFFFFFFE, 32'h00000001);
    check("div lo", LO, 32'hFFFFFFFD);
    check("div hi", HI, 32'hFFFFFFFF);

    launch(4'd4, 32'd1234, 32'd0);
    wait_busy(10, "divu0", 32'hFFFFFFFF, 32'hFFFFFFFD);
    check("divu0 hi", HI, 32'hFFFFFFFF);
    check("divu0 lo", LO, 32'hFFFFFFFD);

    launch(4'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_busy(10, "divovf", 32'hFFFFFFFF, 32'hFFFFFFFD);
    check("divovf lo", LO, 32'h80000000);
    check("divovf hi", HI, 32'h00000000);

    launch(4'd4, 32'd100, 32'd7);
    wait_busy(10, "divu", 32'h00000000, 32'h80000000);
    check("divu lo", LO, 32'd14);
    check("divu hi", HI, 32'd2);

    MDUOp = 4'd7; A = 32'h12345678;
    step();
    MDUOp = 4'd5; #1;
    check("mthi/mfhi", MDUOut, 32'h12345678);
    MDUOp = 4'd0;

    // MTLO held throughout BUSY is ignored; only the op result lands in LO
    launch(4'd1, 32'd2, 32'd3);
    MDUOp = 4'd8; A = 32'h0000AAAA;
    wait_busy(5, "mtlo busy", 32'h12345678, 32'd14);
    MDUOp = 4'd0;
    check("mtlo busy lo", LO, 32'd6);
    check("mtlo busy hi", HI, 32'd0);

    MDUOp = 4'd8; A = 32'h00C0FFEE;
    step();
    MDUOp = 4'd0;
    check("mtlo idle", LO, 32'h00C0FFEE);

    // start with a non-launch op is ignored
    MDUOp = 4'd5; MDUStart = 1'b1;
    step();
    MDUStart = 1'b0; MDUOp = 4'd0;
    check("bad op no launch", {31'd0, Busy}, 32'd0);

    // restarts at cycles 2 and 5 of a multiply are dropped
    launch(4'd1, 32'd5, 32'd7);
    for (int k = 1; k <= 5; k++) begin
      MDUOp = 4'd1; A = 32'd100; B = 32'd100;
      MDUStart = (k == 2 || k == 5);
      check("restart busy", {31'd0, Busy}, 32'd1);
      step();
    end
    MDUStart = 1'b0; MDUOp = 4'd0;
    check("restart done", {31'd0, Busy}, 32'd0);
    check("restart lo", LO, 32'd35);
    check("restart hi", HI, 32'd0);
    step();
    check("restart T+6", {31'd0, Busy}, 32'd0);

    // reset during cycle 4 of a divide
    launch(4'd3, 32'd100, 32'd7);
    step(); step(); step();
    #2 reset = 1'b1;
    #1;
    check("arst busy", {31'd0, Busy}, 32'd0);
    check("arst hi", HI, 32'd0);
    check("arst lo", LO, 32'd0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("post rst busy", {31'd0, Busy}, 32'd0);
      check("post rst hi", HI, 32'd0);
      check("post rst lo", LO, 32'd0);
      step();
    end

    launch(4'd2, 32'd7, 32'd6);
    wait_busy(5, "after rst", 32'd0, 32'd0);
    check("after rst lo", LO, 32'd42);
    check("after rst hi", HI, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: E_MDU

Interface
REQ-001 The parameter MULT_CYCLES SHALL default to 5 and set the busy duration of mult/multu.
REQ-002 The parameter DIV_CYCLES SHALL default to 10 and set the busy duration of div/divu.
REQ-003 The port clk SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
REQ-004 The port reset SHALL be an input, 1 bit wide, with asynchronous, active-high reset.
REQ-005 The port MDUOp SHALL be an input, 4 bits wide, carrying the operation code.
- 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO.
- Codes 9-15 are treated as NOP.
REQ-006 The port MDUStart SHALL be an input, 1 bit wide; when high it requests launch of the mult/multu/div/divu operation in MDUOp.
REQ-007 The port A SHALL be an input, 32 bits wide, carrying operand rs (dividend/multiplicand; source for mthi/mtlo).
REQ-008 The port B SHALL be an input, 32 bits wide, carrying operand rt (divisor/multiplier).
REQ-009 The port Busy SHALL be an output, 1 bit wide, high while a launched operation is in progress.
REQ-010 The port MDUOut SHALL be an output, 32 bits wide, carrying read data for mfhi/mflo.
REQ-011 The port HI SHALL be an output, 32 bits wide, carrying the architectural HI register.
REQ-012 The port LO SHALL be an output, 32 bits wide, carrying the architectural LO register.

Function
REQ-013 The block SHALL have two states, IDLE and BUSY, and a cycle counter cnt.
REQ-014 Launch condition: MDUStart=1, MDUOp in {1,2,3,4}, state IDLE at edge T. Action at edge T:
- latch the result into internal staging registers;
- load cnt with MULT_CYCLES or DIV_CYCLES;
- enter BUSY.
REQ-015 In BUSY, cnt SHALL decrement each edge.
- At the edge where cnt reaches 0: copy the staging registers into HI/LO and return to IDLE.
- Net effect: Busy is high for exactly N cycles (T+1..T+N), and the new HI/LO are visible after edge T+N.
REQ-016 MULT SHALL compute {HI,LO} = signed(A)*signed(B), full 64 bits; MULTU SHALL do the same unsigned.
REQ-017 DIV SHALL set LO = signed quotient truncated toward zero and HI = remainder with the sign of the dividend; DIVU SHALL do the same unsigned.
REQ-018 Division with B=0 SHALL still occupy BUSY for DIV_CYCLES but SHALL leave HI and LO unchanged.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0.
REQ-020 MTHI (7) SHALL write HI=A, and MTLO (8) SHALL write LO=A, at the rising edge, only in IDLE; in BUSY they are ignored.
REQ-021 MDUStart asserted while BUSY SHALL be ignored: no relaunch, no operand latch, no counter reload.
REQ-022 MDUStart with MDUOp not in {1,2,3,4} SHALL be ignored.
REQ-023 MDUOut SHALL be combinational:
- HI when MDUOp=5;
- LO when MDUOp=6;
- 0 otherwise;
- it returns the current architectural value even while Busy (stalling is external).
REQ-024 Busy SHALL depend only on state (registered), never combinationally on MDUStart; external hazard logic uses MDUStart|Busy.
REQ-025 Simultaneous completion and new MDUStart at the same edge SHALL commit the old result and ignore the new start (state is still BUSY at that edge).

Reset
REQ-026 Asserting reset SHALL, asynchronously and at any time including mid-operation, force state IDLE, cnt=0, HI=0, LO=0, staging=0, and Busy=0.
REQ-027 An operation in flight at reset SHALL be discarded, and HI/LO SHALL never receive its result.
REQ-028 After reset deasserts, the first edge SHALL accept a launch normally.

Verification
REQ-029 MULT, A=0xFFFFFFFE (-2), B=3, start at edge T -> Busy=1 for cycles T+1..T+5; HI=0xFFFFFFFF and LO=0xFFFFFFFA after edge T+5.
REQ-030 MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 busy cycles, HI=0xFFFFFFFE and LO=0x00000001.
REQ-031 DIV, A=0xFFFFFFF9 (-7), B=2 -> Busy for 10 cycles; then LO=0xFFFFFFFD (-3) and HI=0xFFFFFFFF (-1). A following DIVU with B=0 -> Busy for 10 cycles, HI/LO unchanged.
REQ-032 MTHI A=0x12345678, then MFHI -> MDUOut=0x12345678; MTLO issued during BUSY -> LO unchanged at completion except by the op result.
REQ-033 Launch DIV, assert reset at cycle 4 of BUSY -> Busy=0 and HI=LO=0 immediately, and they stay 0 through the original completion time.
REQ-034 MDUStart pulsed again at cycles 2 and 5 of a MULT -> single completion at T+5 with the first operands' result, and Busy low at T+6.
